// File: rtl/comp_seq_nbit.sv
// rtl/comp_seq_nbit.sv - sequential WIDTH-bit magnitude comparator, one SLICE-bit digit per cycle, MSB first
// Optional macro COMP_SIGNED_EN adds a signed_mode input for two's-complement operands.
module comp_seq_nbit #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4,
  localparam int NSLICE = WIDTH / SLICE,
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef COMP_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic [IW:0]      slices_used
);

  if ((WIDTH % SLICE) != 0 || NSLICE < 1) begin : g_bad_width
    $error("comp_seq_nbit: WIDTH must be a positive multiple of SLICE");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic [IW:0]      cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [SLICE-1:0] da;
  logic [SLICE-1:0] db;
`ifdef COMP_SIGNED_EN
  logic             signed_q;
`endif

  assign in_ready = (state == IDLE);

  // Digit under test; in signed mode the sign bit of the top digit is flipped so
  // an unsigned digit compare orders two's-complement values correctly.
  always_comb begin
    a_sh = a_q >> (int'(idx) * SLICE);
    b_sh = b_q >> (int'(idx) * SLICE);
    da   = a_sh[SLICE-1:0];
    db   = b_sh[SLICE-1:0];
`ifdef COMP_SIGNED_EN
    if (signed_q && (idx == IW'(NSLICE - 1))) begin
      da[SLICE-1] = ~da[SLICE-1];
      db[SLICE-1] = ~db[SLICE-1];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx         <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      lt          <= 1'b0;
      gt          <= 1'b0;
      eq          <= 1'b0;
      slices_used <= '0;
`ifdef COMP_SIGNED_EN
      signed_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            idx   <= IW'(NSLICE - 1);
            cnt   <= '0;
`ifdef COMP_SIGNED_EN
            signed_q <= signed_mode;
`endif
            state <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (da > db) begin
            gt          <= 1'b1;
            lt          <= 1'b0;
            eq          <= 1'b0;
            out_valid   <= 1'b1;
            slices_used <= cnt + 1'b1;
            state       <= DONE;
          end else if (da < db) begin
            gt          <= 1'b0;
            lt          <= 1'b1;
            eq          <= 1'b0;
            out_valid   <= 1'b1;
            slices_used <= cnt + 1'b1;
            state       <= DONE;
          end else if (idx == '0) begin
            gt          <= 1'b0;
            lt          <= 1'b0;
            eq          <= 1'b1;
            out_valid   <= 1'b1;
            slices_used <= cnt + 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
